tc_sram_stream_adapter: RTL and testbench

- Upstream stage of the single-port tc_sram macro bank.
- Converts a valid/ready memory request stream (read/write, byte enables) into the SRAM's req/we/addr/wdata/be strobes.
- Tracks reads in flight through the fixed SRAM read latency and buffers read data in a response FIFO, so downstream back-pressure never loses data.
- Flags out-of-range addresses with an error response instead of touching the SRAM.

---
 rtl/tc_sram_stream_adapter.sv | 141 ++++++++++++++
 tb/tb_tc_sram_stream_adapter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_sram_stream_adapter.sv
// Request-stream to tc_sram strobe adapter with in-order read responses.
// Credits cover FIFO occupancy plus reads in flight, so the FIFO never overflows.
module tc_sram_stream_adapter #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned Latency   = 1,
  parameter int unsigned RespDepth = 4,
  localparam int unsigned AddrWidth =
    (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth =
    (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [31:0]          req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  input  logic [BeWidth-1:0]   req_be_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 sram_req_o,
  output logic                 sram_we_o,
  output logic [AddrWidth-1:0] sram_addr_o,
  output logic [DataWidth-1:0] sram_wdata_o,
  output logic [BeWidth-1:0]   sram_be_o,
  input  logic [DataWidth-1:0] sram_rdata_i
);

  localparam int unsigned PtrW =
    (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  localparam int unsigned EntW = DataWidth + 1;

  logic [CntW-1:0]    credit_q, credit_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [EntW-1:0]    mem_q [RespDepth];
  logic [EntW-1:0]    mem_d [RespDepth];
  logic [Latency-1:0] pv_q, pv_d;
  logic [Latency-1:0] pe_q, pe_d;

  logic in_range;
  logic fire;
  logic rd_fire;
  logic push;
  logic pop;
  logic [EntW-1:0] push_ent;

  always_comb begin
    in_range    = req_addr_i < 32'(NumWords);
    req_ready_o = !rst_i &&
      (req_we_i || credit_q < CntW'(RespDepth));
    fire        = req_valid_i && req_ready_o;
    rd_fire     = fire && !req_we_i;

    sram_req_o   = fire && in_range;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i[AddrWidth-1:0];
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;

    resp_valid_o = count_q != '0;
    resp_rdata_o = mem_q[rptr_q][DataWidth-1:0];
    resp_err_o   = mem_q[rptr_q][DataWidth];
    pop          = resp_valid_o && resp_ready_i;

    // Error entries carry zero data instead of whatever the SRAM drives.
    push     = pv_q[Latency-1];
    push_ent = pe_q[Latency-1] ?
      {1'b1, {DataWidth{1'b0}}} : {1'b0, sram_rdata_i};
  end

  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pv_d[0] = rd_fire;
    pe_d[0] = !in_range;
    for (int i = 1; i < int'(Latency); i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    credit_d = credit_q + CntW'(rd_fire) - CntW'(pop);
    if (push) begin
      mem_d[wptr_q] = push_ent;
      wptr_d = (wptr_q == PtrW'(RespDepth - 1)) ?
        '0 : wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PtrW'(RespDepth - 1)) ?
        '0 : rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit_q <= '0;
      count_q  <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      pv_q     <= '0;
      pe_q     <= '0;
    end else begin
      credit_q <= credit_d;
      count_q  <= count_d;
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      pv_q     <= pv_d;
      pe_q     <= pe_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  a_credit_max: assert property (
    @(posedge clk_i) disable iff (rst_i)
    credit_q <= CntW'(RespDepth));

  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (rst_i)
    push |-> (count_q < CntW'(RespDepth)) || pop);

  a_valid_hold: assert property (
    @(posedge clk_i) disable iff (rst_i)
    resp_valid_o && !resp_ready_i |=> resp_valid_o);

endmodule

// File: tb/tb_tc_sram_stream_adapter.sv
// Bench for tc_sram_stream_adapter: random and directed traffic
// against a response-queue model with a behavioural SRAM attached.
module tb_tc_sram_stream_adapter;

  localparam int NW  = 256;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int RD  = 4;
  localparam int AW  = 8;
  localparam int BW  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [31:0]   req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [BW-1:0] req_be_i;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic          sram_req_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [BW-1:0] sram_be_o;
  logic [DW-1:0] sram_rdata_i;

  always #5 clk_i = ~clk_i;

  tc_sram_stream_adapter #(
    .NumWords (NW),
    .DataWidth(DW),
    .ByteWidth(8),
    .Latency  (LAT),
    .RespDepth(RD)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o),
    .resp_err_o  (resp_err_o),
    .sram_req_o  (sram_req_o),
    .sram_we_o   (sram_we_o),
    .sram_addr_o (sram_addr_o),
    .sram_wdata_o(sram_wdata_o),
    .sram_be_o   (sram_be_o),
    .sram_rdata_i(sram_rdata_i)
  );

  // Behavioural SRAM with fixed read latency.
  logic [DW-1:0] sram_mem [NW];
  logic [DW-1:0] line_q [LAT];
  bit            mem_init;

  always @(posedge clk_i) begin
    for (int i = LAT - 1; i > 0; i--) line_q[i] <= line_q[i-1];
    line_q[0] <= sram_mem[sram_addr_o];
    if (mem_init) begin
      for (int i = 0; i < NW; i++)
        sram_mem[i] <= i * 32'h9E3779B9 + 32'd1;
    end else if (sram_req_o && sram_we_o) begin
      for (int b = 0; b < BW; b++)
        if (sram_be_o[b])
          sram_mem[sram_addr_o][8*b +: 8] <= sram_wdata_o[8*b +: 8];
    end
  end

  assign sram_rdata_i = line_q[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            avail;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] gold [NW];
  int            cyc;
  int            n_tests;
  int            n_fail;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(bit v, bit we, logic [31:0] a,
                      logic [31:0] d, logic [3:0] be, bit rr);
    bit   rdy;
    bit   fire;
    bit   inr;
    bit   exp_v;
    rsp_t r;
    req_valid_i  = v;
    req_we_i     = we;
    req_addr_i   = a;
    req_wdata_i  = d;
    req_be_i     = be;
    resp_ready_i = rr;
    @(negedge clk_i);
    rdy  = we || (exp_q.size() < RD);
    fire = v && rdy;
    inr  = a < NW;
    check("req_ready", req_ready_o, rdy);
    check("sram_req", sram_req_o, fire && inr);
    if (fire && inr) begin
      check("sram_addr", sram_addr_o, a[AW-1:0]);
      check("sram_we", sram_we_o, we);
    end
    exp_v = exp_q.size() > 0 && exp_q[0].avail <= cyc;
    check("resp_valid", resp_valid_o, exp_v);
    if (exp_v) begin
      check("resp_rdata", resp_rdata_o, exp_q[0].data);
      check("resp_err", resp_err_o, exp_q[0].err);
    end
    if (fire && we && inr)
      for (int b = 0; b < BW; b++)
        if (be[b]) gold[a[AW-1:0]][8*b +: 8] = d[8*b +: 8];
    if (exp_v && rr) void'(exp_q.pop_front());
    if (fire && !we) begin
      r.data  = inr ? gold[a[AW-1:0]] : '0;
      r.err   = !inr;
      r.avail = cyc + LAT + 1;
      exp_q.push_back(r);
    end
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(bit rr);
    step(1'b0, 1'b0, 32'd0, 32'd0, 4'd0, rr);
  endtask

  task automatic rd(logic [31:0] a, bit rr);
    step(1'b1, 1'b0, a, $urandom, 4'hF, rr);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) idle(1'b1);
    check("drain_done", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check("rst_resp_valid", resp_valid_o, 1'b0);
    check("rst_req_ready", req_ready_o, 1'b0);
    check("rst_sram_req", sram_req_o, 1'b0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    cyc++;
    rst_i = 1'b0;
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    cyc          = 0;
    mem_init     = 1'b1;
    rst_i        = 1'b1;
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_be_i     = '0;
    resp_ready_i = 1'b1;
    for (int i = 0; i < NW; i++) gold[i] = i * 32'h9E3779B9 + 32'd1;
    #1;
    check("reset_resp_valid", resp_valid_o, 1'b0);
    check("reset_req_ready", req_ready_o, 1'b0);
    check("reset_sram_req", sram_req_o, 1'b0);
    @(posedge clk_i);
    #1;
    mem_init = 1'b0;
    rst_i    = 1'b0;

    // Write then read back.
    step(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1);
    rd(32'd5, 1'b1);
    drain();

    // Partial write keeps the upper bytes.
    step(1'b1, 1'b1, 32'd5, 32'h11223344, 4'h3, 1'b1);
    rd(32'd5, 1'b1);
    drain();

    // Out-of-range read and write.
    rd(32'd1, 1'b1);
    rd(32'd300, 1'b1);
    rd(32'd2, 1'b1);
    step(1'b1, 1'b1, 32'd300, 32'hCAFEF00D, 4'hF, 1'b1);
    drain();

    // Back-pressure: credits run out, writes still pass.
    for (int i = 0; i < 6; i++) rd(32'd10 + i, 1'b0);
    step(1'b1, 1'b1, 32'd20, 32'h0BADF00D, 4'hF, 1'b0);
    idle(1'b0);
    for (int i = 0; i < 3; i++) rd(32'd30 + i, 1'b1);
    drain();

    // Back-to-back streaming with the consumer always ready.
    for (int i = 0; i < 20; i++) rd($urandom_range(0, NW - 1), 1'b1);
    drain();

    // Reset with reads both queued and in flight.
    for (int i = 0; i < 4; i++) rd(32'd40 + i, 1'b0);
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) rd(32'd50 + i, 1'b0);
    idle(1'b0);
    drain();

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0,
           ($urandom_range(0, 9) == 0) ?
             32'($urandom_range(NW, 400)) :
             32'($urandom_range(0, NW - 1)),
           $urandom,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
